// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared widths, FSM state encoding and default halt opcode for
//            the instruction fetch sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  localparam logic [1:0] FS_IDLE   = 2'd0;
  localparam logic [1:0] FS_FETCH  = 2'd1;
  localparam logic [1:0] FS_DRAIN  = 2'd2;
  localparam logic [1:0] FS_HALTED = 2'd3;

  localparam logic [INSTR_W-1:0] HALT_INSTR_DEFAULT = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/fetch_out_reg.sv
// ============================================================================
// Module   : fetch_out_reg
// Purpose  : One-entry valid/ready output register carrying an instruction
//            and its fetch address, with a flush that discards the entry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_out_reg #(
  parameter int DATA_W = fetch_pkg::INSTR_W,
  parameter int PC_W   = fetch_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [PC_W-1:0]   load_pc,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic [PC_W-1:0]   pc,
  output logic              valid
);

  logic [DATA_W-1:0] r_data;
  logic [PC_W-1:0]   r_pc;
  logic              r_valid;

  // Flush outranks a load so a redirected entry can never reach decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_pc    <= load_pc;
      r_valid <= 1'b1;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign data  = r_data;
  assign pc    = r_pc;
  assign valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Fetch sequencer owning the PC for a combinational instruction
//            ROM; optional transfer counter under IMEM_FETCH_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                 MEM_DEPTH  = 32,
  parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEFAULT,
  parameter int                 ADDR_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               busy,
  output logic               halted
`ifdef IMEM_FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_count
`endif
);

  localparam logic [ADDR_W-1:0] C_PC_MASK = ADDR_W'(MEM_DEPTH - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_active;
  logic              w_start_ok;
  logic              w_flush;
  logic              w_load;
  logic              w_is_halt;
  logic              w_xfer;
  logic              w_valid;

  assign w_active   = (r_state == FS_FETCH) || (r_state == FS_DRAIN);
  assign w_start_ok = start && ((r_state == FS_IDLE) || (r_state == FS_HALTED));
  assign w_flush    = redirect && w_active;
  assign w_load     = (r_state == FS_FETCH) && !w_flush && (!w_valid || instr_ready);
  assign w_is_halt  = (imem_data == HALT_INSTR);
  // A transfer coinciding with a redirect is discarded, not delivered.
  assign w_xfer     = w_valid && instr_ready && !w_flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FS_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FS_IDLE, FS_HALTED: begin
        if (start) w_state_next = FS_FETCH;
      end
      FS_FETCH: begin
        if (w_flush)                    w_state_next = FS_FETCH;
        else if (w_load && w_is_halt)   w_state_next = FS_DRAIN;
      end
      FS_DRAIN: begin
        if (w_flush)     w_state_next = FS_FETCH;
        else if (w_xfer) w_state_next = FS_HALTED;
      end
      default: w_state_next = FS_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    halted = 1'b0;
    case (r_state)
      FS_FETCH, FS_DRAIN: busy   = 1'b1;
      FS_HALTED:          halted = 1'b1;
      default: ;
    endcase
  end

  // The PC parks on the halt address so imem_addr points at it while draining.
  always_comb begin
    w_pc_next = r_pc;
    if (w_start_ok) begin
      w_pc_next = start_addr & C_PC_MASK;
    end else if (w_flush) begin
      w_pc_next = redirect_addr & C_PC_MASK;
    end else if (w_load && !w_is_halt) begin
      w_pc_next = (r_pc + ADDR_W'(1)) & C_PC_MASK;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign imem_addr = r_pc;

  fetch_out_reg #(
    .DATA_W (INSTR_W),
    .PC_W   (ADDR_W)
  ) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (w_flush),
    .load      (w_load),
    .load_data (imem_data),
    .load_pc   (r_pc),
    .ready     (instr_ready),
    .data      (instr),
    .pc        (instr_pc),
    .valid     (w_valid)
  );

  assign instr_valid = w_valid;

`ifdef IMEM_FETCH_PERF_CNT_EN
  logic [15:0] r_perf_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_count <= '0;
    end else if (w_start_ok) begin
      r_perf_count <= '0;
    end else if (w_xfer && (r_perf_count != 16'hFFFF)) begin
      r_perf_count <= r_perf_count + 16'd1;
    end
  end

  assign perf_count = r_perf_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Purpose  : Self-checking bench for imem_fetch_ctrl with a ROM model and a
//            queue-based expected fetch stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] start_addr;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect;
  logic [7:0] redirect_addr;
  logic       busy;
  logic       halted;
`ifdef IMEM_FETCH_PERF_CNT_EN
  logic [15:0] perf_count;
`endif

  logic [7:0] rom [0:255];
  logic [7:0] q_pc [$];
  logic [7:0] q_in [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign imem_data = rom[imem_addr];

  imem_fetch_ctrl #(
    .MEM_DEPTH  (32),
    .HALT_INSTR (8'hFF),
    .ADDR_W     (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .start_addr    (start_addr),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .busy          (busy),
    .halted        (halted)
`ifdef IMEM_FETCH_PERF_CNT_EN
    ,
    .perf_count    (perf_count)
`endif
  );

  // Expected stream: consecutive addresses mod 32 up to and including the halt word.
  function automatic void build_expected(input logic [7:0] addr);
    int a;
    a = int'(addr) % 32;
    q_pc.delete();
    q_in.delete();
    for (int i = 0; i < 64; i++) begin
      q_pc.push_back(8'(a));
      q_in.push_back(rom[a]);
      if (rom[a] == 8'hFF) break;
      a = (a + 1) % 32;
    end
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; start_addr = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_addr = '0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    step; step;
    n_cmp++;
    if ({imem_addr, instr, instr_pc, instr_valid, busy, halted} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_values: got %h expected 0",
               {imem_addr, instr, instr_pc, instr_valid, busy, halted});
    end
    #2 reset_n = 1'b1;
    step; step;
    n_cmp++;
    if ({imem_addr, instr_valid, busy, halted} !== 11'd0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %h expected 0",
               {imem_addr, instr_valid, busy, halted});
    end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 10; i++) rom[i] = 8'(($urandom_range(0, 14) << 4) | i);
    rom[10] = 8'hFF;
    build_expected(8'd0);
    instr_ready = 1'b1; start_addr = 8'd0; start = 1'b1;
    step;
    start = 1'b0;
    n_cmp++;
    if ({imem_addr, instr_valid, busy} !== {8'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL stream_start_latency: got addr=%h v=%b busy=%b expected addr=00 v=0 busy=1",
               imem_addr, instr_valid, busy);
    end
    step;
    for (int k = 0; k < 11; k++) begin
      n_cmp++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, q_pc[k], q_in[k]}) begin
        n_err++;
        $display("FAIL stream_seq[%0d]: got v=%b pc=%h in=%h expected v=1 pc=%h in=%h",
                 k, instr_valid, instr_pc, instr, q_pc[k], q_in[k]);
      end
      step;
    end
    n_cmp++;
    if ({halted, busy, instr_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL stream_halt: got halted/busy/valid=%b expected 100",
               {halted, busy, instr_valid});
    end
`ifdef IMEM_FETCH_PERF_CNT_EN
    n_cmp++;
    if (perf_count !== 16'd11) begin
      n_err++;
      $display("FAIL stream_perf: got %0d expected 11", perf_count);
    end
`endif
  endtask

  task automatic test_backpressure;
    int guard;
    start_addr = 8'd0; start = 1'b1; instr_ready = 1'b1;
    step;
    start = 1'b0;
    guard = 0;
    while (!(instr_valid === 1'b1 && instr_pc === 8'd3) && guard < 20) begin
      step;
      guard++;
    end
    n_cmp++;
    if (guard >= 20) begin
      n_err++;
      $display("FAIL bp_wait: got timeout expected instr_pc=03");
    end
    instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step;
      n_cmp++;
      if ({instr_valid, instr_pc, instr, imem_addr} !== {1'b1, 8'd3, rom[3], 8'd4}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b pc=%h in=%h addr=%h expected v=1 pc=03 in=%h addr=04",
                 c, instr_valid, instr_pc, instr, imem_addr, rom[3]);
      end
    end
    instr_ready = 1'b1;
    step;
    for (int e = 4; e <= 10; e++) begin
      n_cmp++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 8'(e), rom[e]}) begin
        n_err++;
        $display("FAIL bp_resume[%0d]: got v=%b pc=%h in=%h expected v=1 pc=%h in=%h",
                 e, instr_valid, instr_pc, instr, 8'(e), rom[e]);
      end
      step;
    end
    n_cmp++;
    if (halted !== 1'b1) begin
      n_err++;
      $display("FAIL bp_halt: got halted=%b expected 1", halted);
    end
  endtask

  task automatic test_wrap;
    int guard;
    int total;
    logic prev_stall;
    logic [7:0] prev_pc, prev_in;
    rom[30] = 8'h5A; rom[31] = 8'hA5;
    build_expected(8'd62);
    total = q_pc.size();
    start_addr = 8'd62; start = 1'b1; instr_ready = 1'b1;
    step;
    start = 1'b0;
    n_cmp++;
    if (imem_addr !== 8'd30) begin
      n_err++;
      $display("FAIL wrap_mask: got addr=%h expected 1e", imem_addr);
    end
    guard = 0; prev_stall = 1'b0; prev_pc = '0; prev_in = '0;
    while (!halted && guard < 400) begin
      instr_ready = ($urandom % 3) != 0;
      if (prev_stall) begin
        n_cmp++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, prev_pc, prev_in}) begin
          n_err++;
          $display("FAIL wrap_stall_hold: got v=%b pc=%h in=%h expected v=1 pc=%h in=%h",
                   instr_valid, instr_pc, instr, prev_pc, prev_in);
        end
      end
      if (instr_valid && instr_ready) begin
        n_cmp++;
        if (q_pc.size() == 0 || {instr_pc, instr} !== {q_pc[0], q_in[0]}) begin
          n_err++;
          $display("FAIL wrap_xfer: got pc=%h in=%h expected pc=%h in=%h (left %0d)",
                   instr_pc, instr, q_pc.size() ? q_pc[0] : 8'h00,
                   q_in.size() ? q_in[0] : 8'h00, q_pc.size());
        end
        if (q_pc.size() > 0) begin
          void'(q_pc.pop_front());
          void'(q_in.pop_front());
        end
      end
      prev_stall = instr_valid && !instr_ready;
      prev_pc = instr_pc;
      prev_in = instr;
      step;
      guard++;
    end
    n_cmp++;
    if (halted !== 1'b1 || q_pc.size() != 0) begin
      n_err++;
      $display("FAIL wrap_end: got halted=%b left=%0d expected halted=1 left=0",
               halted, q_pc.size());
    end
`ifdef IMEM_FETCH_PERF_CNT_EN
    n_cmp++;
    if (perf_count !== 16'(total)) begin
      n_err++;
      $display("FAIL wrap_perf: got %0d expected %0d", perf_count, total);
    end
`endif
  endtask

  task automatic test_redirect_stall;
    int guard;
    start_addr = 8'd0; start = 1'b1; instr_ready = 1'b1;
    step;
    start = 1'b0;
    step;
    instr_ready = 1'b0;
    step;
    redirect = 1'b1; redirect_addr = 8'd5; instr_ready = 1'b1;
    step;
    redirect = 1'b0;
    n_cmp++;
    if ({instr_valid, imem_addr} !== {1'b0, 8'd5}) begin
      n_err++;
      $display("FAIL redir_flush: got v=%b addr=%h expected v=0 addr=05", instr_valid, imem_addr);
    end
`ifdef IMEM_FETCH_PERF_CNT_EN
    n_cmp++;
    if (perf_count !== 16'd0) begin
      n_err++;
      $display("FAIL redir_perf_flushed: got %0d expected 0", perf_count);
    end
`endif
    step;
    n_cmp++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 8'd5, rom[5]}) begin
      n_err++;
      $display("FAIL redir_target: got v=%b pc=%h in=%h expected v=1 pc=05 in=%h",
               instr_valid, instr_pc, instr, rom[5]);
    end
    guard = 0;
    while (!halted && guard < 40) begin
      step;
      guard++;
    end
    n_cmp++;
    if (halted !== 1'b1) begin
      n_err++;
      $display("FAIL redir_drain: got halted=%b expected 1", halted);
    end
`ifdef IMEM_FETCH_PERF_CNT_EN
    n_cmp++;
    if (perf_count !== 16'd6) begin
      n_err++;
      $display("FAIL redir_perf_total: got %0d expected 6", perf_count);
    end
`endif
  endtask

  task automatic test_control;
    redirect = 1'b1; redirect_addr = 8'd7;
    step;
    redirect = 1'b0;
    n_cmp++;
    if ({halted, busy, instr_valid, imem_addr} !== {3'b100, 8'd10}) begin
      n_err++;
      $display("FAIL ctl_redirect_halted: got h/b/v=%b addr=%h expected 100 addr=0a",
               {halted, busy, instr_valid}, imem_addr);
    end
    start = 1'b1; start_addr = 8'd2; instr_ready = 1'b1;
    step;
    start = 1'b0;
    n_cmp++;
    if ({halted, busy, imem_addr} !== {2'b01, 8'd2}) begin
      n_err++;
      $display("FAIL ctl_restart: got h/b=%b addr=%h expected 01 addr=02",
               {halted, busy}, imem_addr);
    end
    step;
    n_cmp++;
    if ({instr_valid, instr_pc} !== {1'b1, 8'd2}) begin
      n_err++;
      $display("FAIL ctl_restart_pc: got v=%b pc=%h expected v=1 pc=02", instr_valid, instr_pc);
    end
    start = 1'b1; start_addr = 8'd20;
    step;
    start = 1'b0;
    n_cmp++;
    if ({instr_valid, instr_pc, imem_addr, busy} !== {1'b1, 8'd3, 8'd4, 1'b1}) begin
      n_err++;
      $display("FAIL ctl_start_busy: got v=%b pc=%h addr=%h busy=%b expected v=1 pc=03 addr=04 busy=1",
               instr_valid, instr_pc, imem_addr, busy);
    end
  endtask

  task automatic test_async_reset;
    step;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({imem_addr, instr, instr_pc, instr_valid, busy, halted} !== 27'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h expected 0",
               {imem_addr, instr, instr_pc, instr_valid, busy, halted});
    end
`ifdef IMEM_FETCH_PERF_CNT_EN
    n_cmp++;
    if (perf_count !== 16'd0) begin
      n_err++;
      $display("FAIL async_reset_perf: got %0d expected 0", perf_count);
    end
`endif
    @(posedge clk);
    #3 reset_n = 1'b1;
    step; step;
    n_cmp++;
    if ({imem_addr, instr_valid, busy, halted} !== 11'd0) begin
      n_err++;
      $display("FAIL async_reset_idle: got %h expected 0", {imem_addr, instr_valid, busy, halted});
    end
  endtask

  task automatic test_random;
    int guard;
    int n_x;
    int h;
    logic prev_stall;
    logic [7:0] prev_pc, prev_in;
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < 32; a++) rom[a] = 8'($urandom_range(0, 254));
      h = $urandom_range(0, 31);
      rom[h] = 8'hFF;
      start_addr = 8'($urandom);
      build_expected(start_addr);
      start = 1'b1; instr_ready = 1'b1;
      step;
      start = 1'b0;
      guard = 0; n_x = 0; prev_stall = 1'b0; prev_pc = '0; prev_in = '0;
      while (!halted && guard < 600) begin
        instr_ready   = ($urandom % 4) != 0;
        redirect      = busy && (guard < 300) && (($urandom % 12) == 0);
        redirect_addr = 8'($urandom);
        if (prev_stall) begin
          n_cmp++;
          if ({instr_valid, instr_pc, instr} !== {1'b1, prev_pc, prev_in}) begin
            n_err++;
            $display("FAIL rand_stall_hold[%0d]: got v=%b pc=%h in=%h expected v=1 pc=%h in=%h",
                     it, instr_valid, instr_pc, instr, prev_pc, prev_in);
          end
        end
        if (redirect) begin
          build_expected(redirect_addr);
        end else if (instr_valid && instr_ready) begin
          n_cmp++;
          n_x++;
          if (q_pc.size() == 0 || {instr_pc, instr} !== {q_pc[0], q_in[0]}) begin
            n_err++;
            $display("FAIL rand_xfer[%0d]: got pc=%h in=%h expected pc=%h in=%h (left %0d)",
                     it, instr_pc, instr, q_pc.size() ? q_pc[0] : 8'h00,
                     q_in.size() ? q_in[0] : 8'h00, q_pc.size());
          end
          if (q_pc.size() > 0) begin
            void'(q_pc.pop_front());
            void'(q_in.pop_front());
          end
        end
        prev_stall = instr_valid && !instr_ready && !redirect;
        prev_pc = instr_pc;
        prev_in = instr;
        step;
        guard++;
      end
      redirect = 1'b0;
      n_cmp++;
      if (halted !== 1'b1 || q_pc.size() != 0) begin
        n_err++;
        $display("FAIL rand_end[%0d]: got halted=%b left=%0d expected halted=1 left=0",
                 it, halted, q_pc.size());
      end
`ifdef IMEM_FETCH_PERF_CNT_EN
      n_cmp++;
      if (perf_count !== 16'(n_x)) begin
        n_err++;
        $display("FAIL rand_perf[%0d]: got %0d expected %0d", it, perf_count, n_x);
      end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_wrap;
    test_redirect_stall;
    test_control;
    test_async_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion expected summary before 500000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
